ctx_wrq_queue: RTL and testbench

//  Downstream of the SNES bus-snoop context capture. Buffers its one-cycle write requests (addr/data/word) in a FIFO.

---
 rtl/ctx_wrq_queue.sv | 254 +++++++++++++++++++++++++
 tb/tb_ctx_wrq_queue.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctx_wrq_queue.sv
// ctx_wrq_queue
// Write-request queue that sits behind the bus-snoop context capture.
// One-cycle write strobes (address/data/word flag) are stored in a small FIFO.
// They are then replayed to the memory arbiter as single-cycle BUS_WRQ pulses.
// Each replay waits for the arbiter's BUS_RDY handshake before the next one starts.
// If WORD_SPLIT is set, a 16-bit entry is sent as two byte writes: the low byte
// goes to addr and the high byte goes to addr+1.
//
// Parameters
//   DEPTH_LOG2  FIFO depth is 2**DEPTH_LOG2 entries of {addr24, data16, word1}
//   WORD_SPLIT  1 = send word entries as two byte writes, 0 = send them unchanged
//   RDY_GRACE   number of WAIT_LO cycles to watch for BUS_RDY to drop before
//               treating the write as already serviced (must be >= 1)
//
// Ports
//   clkin, reset      clock (rising edge), asynchronous active-high reset
//   IN_WRQ/ADDR/DATA/WORD   push strobe and entry from the snoop stage
//   BUS_RDY           arbiter idle level; it is low while a write is being serviced
//   BUS_WRQ           one-cycle write request pulse
//   ROM_ADDR/DATA/WORD_ENABLE  current write; these hold their value between transactions
//   FIFO_LEVEL/FULL/EMPTY      number of queued entries (the in-flight write is not counted)
//   OVF_CNT / OVF_CLR  saturating count of dropped pushes, and its synchronous clear
module ctx_wrq_queue #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WORD_SPLIT = 0,
   parameter int RDY_GRACE  = 4
) (
   input  logic                clkin,
   input  logic                reset,
   input  logic                IN_WRQ,
   input  logic [23:0]         IN_ADDR,
   input  logic [15:0]         IN_DATA,
   input  logic                IN_WORD,
   input  logic                BUS_RDY,
   output logic                BUS_WRQ,
   output logic [23:0]         ROM_ADDR,
   output logic [15:0]         ROM_DATA,
   output logic                ROM_WORD_ENABLE,
   output logic [DEPTH_LOG2:0] FIFO_LEVEL,
   output logic                FIFO_FULL,
   output logic                FIFO_EMPTY,
   output logic [7:0]          OVF_CNT,
   input  logic                OVF_CLR
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int GW    = (RDY_GRACE < 2) ? 1 : $clog2(RDY_GRACE);

   localparam logic [DEPTH_LOG2:0]   LEVEL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   LEVEL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [GW-1:0]         GRACE_END = GW'(RDY_GRACE - 1);
   localparam logic [GW-1:0]         GRACE_ONE = GW'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_LO,
      ST_WAIT_HI,
      ST_DONE,
      ST_ISSUE2
   } state_t;

   // FIFO storage. It has an asynchronous read so that an entry pushed on
   // one edge can be popped on the next edge.
   logic [40:0] mem [DEPTH];

   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic [7:0]            ovf_q, ovf_d;

   state_t                state_q;
   logic [GW-1:0]         grace_q;
   logic                  split_pend_q;
   logic [7:0]            split_hi_q;
   logic                  bus_wrq_q;
   logic [23:0]           rom_addr_q;
   logic [15:0]           rom_data_q;
   logic                  rom_word_q;

   logic        full, empty, pop, push, drop;
   logic [40:0] rd_entry;
   logic [23:0] load_addr_d;
   logic [15:0] load_data_d;
   logic        load_word_d;
   logic        load_split_d;

   assign full     = (level_q == LEVEL_MAX);
   assign empty    = (level_q == '0);
   assign rd_entry = mem[rd_ptr_q];

   // A pop happens only when the FSM is about to enter ISSUE. This can be
   // from IDLE, or from DONE when there is no second byte still pending.
   always_comb begin
      pop = 1'b0;
      if (!empty && BUS_RDY) begin
         if (state_q == ST_IDLE) begin
            pop = 1'b1;
         end else if (state_q == ST_DONE && !split_pend_q) begin
            pop = 1'b1;
         end
      end
   end

   // A pop on the same edge frees a slot, so a full FIFO can still accept a push.
   assign push = IN_WRQ && (!full || pop);
   assign drop = IN_WRQ && full && !pop;

   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + LEVEL_ONE;
      end else if (pop && !push) begin
         level_d = level_q - LEVEL_ONE;
      end
   end

   // The clear takes priority over an increment in the same cycle.
   // The counter saturates at 255.
   always_comb begin
      ovf_d = ovf_q;
      if (OVF_CLR) begin
         ovf_d = 8'd0;
      end else if (drop && ovf_q != 8'hFF) begin
         ovf_d = ovf_q + 8'd1;
      end
   end

   // Values to load into the ROM_* registers when an entry is popped. When
   // splitting, the first write carries the low byte in both halves. The high
   // byte is saved for the follow-up write to addr+1.
   always_comb begin
      load_addr_d  = rd_entry[40:17];
      load_data_d  = rd_entry[16:1];
      load_word_d  = rd_entry[0];
      load_split_d = 1'b0;
      if (WORD_SPLIT != 0 && rd_entry[0]) begin
         load_data_d  = {rd_entry[8:1], rd_entry[8:1]};
         load_word_d  = 1'b0;
         load_split_d = 1'b1;
      end
   end

   always_ff @(posedge clkin) begin
      if (push) begin
         mem[wr_ptr_q] <= {IN_ADDR, IN_DATA, IN_WORD};
      end
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 8'd0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         level_q <= level_d;
         ovf_q   <= ovf_d;
      end
   end

   // Transaction FSM. BUS_WRQ is registered: it is set on the edge that
   // enters ISSUE or ISSUE2, so the pulse lasts exactly one cycle.
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         grace_q      <= '0;
         split_pend_q <= 1'b0;
         split_hi_q   <= 8'd0;
         bus_wrq_q    <= 1'b0;
         rom_addr_q   <= 24'd0;
         rom_data_q   <= 16'd0;
         rom_word_q   <= 1'b0;
      end else begin
         bus_wrq_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  rom_addr_q   <= load_addr_d;
                  rom_data_q   <= load_data_d;
                  rom_word_q   <= load_word_d;
                  split_pend_q <= load_split_d;
                  split_hi_q   <= rd_entry[16:9];
                  bus_wrq_q    <= 1'b1;
                  state_q      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               grace_q <= '0;
               state_q <= ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
               // A fast arbiter may finish before BUS_RDY is ever seen low.
               // After RDY_GRACE cycles still high, treat the write as done.
               if (!BUS_RDY) begin
                  state_q <= ST_WAIT_HI;
               end else if (grace_q == GRACE_END) begin
                  state_q <= ST_DONE;
               end else begin
                  grace_q <= grace_q + GRACE_ONE;
               end
            end
            ST_WAIT_HI: begin
               if (BUS_RDY) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (split_pend_q) begin
                  rom_addr_q <= rom_addr_q + 24'd1;
                  rom_data_q <= {split_hi_q, split_hi_q};
                  rom_word_q <= 1'b0;
                  bus_wrq_q  <= 1'b1;
                  state_q    <= ST_ISSUE2;
               end else if (pop) begin
                  rom_addr_q   <= load_addr_d;
                  rom_data_q   <= load_data_d;
                  rom_word_q   <= load_word_d;
                  split_pend_q <= load_split_d;
                  split_hi_q   <= rd_entry[16:9];
                  bus_wrq_q    <= 1'b1;
                  state_q      <= ST_ISSUE;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ISSUE2: begin
               split_pend_q <= 1'b0;
               grace_q      <= '0;
               state_q      <= ST_WAIT_LO;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign BUS_WRQ         = bus_wrq_q;
   assign ROM_ADDR        = rom_addr_q;
   assign ROM_DATA        = rom_data_q;
   assign ROM_WORD_ENABLE = rom_word_q;
   assign FIFO_LEVEL      = level_q;
   assign FIFO_FULL       = full;
   assign FIFO_EMPTY      = empty;
   assign OVF_CNT         = ovf_q;

endmodule

// File: tb/tb_ctx_wrq_queue.sv
// Testbench for ctx_wrq_queue.
// There are two instances:
//   dut    uses WORD_SPLIT=0 and a scripted arbiter on BUS_RDY
//   dut_s  uses WORD_SPLIT=1, with BUS_RDY held high
// Every issued write is checked against a scoreboard queue, in order.
`timescale 1ns/1ps
module tb_ctx_wrq_queue;
   localparam int GRACE = 4;

   typedef struct packed {
      logic [23:0] a;
      logic [15:0] d;
      logic        w;
   } wr_t;

   typedef struct {
      logic [23:0] a;
      logic [15:0] d;
      logic        w;
      int          lvl;
      logic        full;
      int          ovf;
   } vec_t;

   logic        clkin = 1'b0;
   logic        reset;
   logic        IN_WRQ, IN_WORD, OVF_CLR;
   logic [23:0] IN_ADDR;
   logic [15:0] IN_DATA;
   logic        BUS_RDY = 1'b1;
   logic        BUS_WRQ, ROM_WORD_ENABLE, FIFO_FULL, FIFO_EMPTY;
   logic [23:0] ROM_ADDR;
   logic [15:0] ROM_DATA;
   logic [4:0]  FIFO_LEVEL;
   logic [7:0]  OVF_CNT;

   logic        s_wrq, s_word;
   logic [23:0] s_addr;
   logic [15:0] s_data;
   logic        s_rdy = 1'b1;
   logic        s_clr = 1'b0;
   logic        s_bus_wrq, s_rom_word, s_full, s_empty;
   logic [23:0] s_rom_addr;
   logic [15:0] s_rom_data;
   logic [4:0]  s_level;
   logic [7:0]  s_ovf;

   int n_cmp = 0;
   int n_err = 0;
   int n_wrq = 0;
   int cyc = 0;
   int rdy_mode = 0;   // 0: BUS_RDY high, 1: low pulse after each BUS_WRQ, 2: held low
   int lo_len = 3;
   int lo_left = 0;
   wr_t q[$];
   wr_t qs[$];
   int  wrq_cyc[$];

   always #5 clkin = ~clkin;
   always @(posedge clkin) cyc <= cyc + 1;

   ctx_wrq_queue #(.DEPTH_LOG2(4), .WORD_SPLIT(0), .RDY_GRACE(GRACE)) dut (
      .clkin(clkin), .reset(reset),
      .IN_WRQ(IN_WRQ), .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA), .IN_WORD(IN_WORD),
      .BUS_RDY(BUS_RDY), .BUS_WRQ(BUS_WRQ), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
      .ROM_WORD_ENABLE(ROM_WORD_ENABLE), .FIFO_LEVEL(FIFO_LEVEL), .FIFO_FULL(FIFO_FULL),
      .FIFO_EMPTY(FIFO_EMPTY), .OVF_CNT(OVF_CNT), .OVF_CLR(OVF_CLR)
   );

   ctx_wrq_queue #(.DEPTH_LOG2(4), .WORD_SPLIT(1), .RDY_GRACE(GRACE)) dut_s (
      .clkin(clkin), .reset(reset),
      .IN_WRQ(s_wrq), .IN_ADDR(s_addr), .IN_DATA(s_data), .IN_WORD(s_word),
      .BUS_RDY(s_rdy), .BUS_WRQ(s_bus_wrq), .ROM_ADDR(s_rom_addr), .ROM_DATA(s_rom_data),
      .ROM_WORD_ENABLE(s_rom_word), .FIFO_LEVEL(s_level), .FIFO_FULL(s_full),
      .FIFO_EMPTY(s_empty), .OVF_CNT(s_ovf), .OVF_CLR(s_clr)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Arbiter model. It updates 2ns after the falling edge, so the test process
   // can change rdy_mode at the falling edge without racing this block.
   always @(negedge clkin) begin
      #2;
      if (rdy_mode == 0) begin
         BUS_RDY = 1'b1;
         lo_left = 0;
      end else if (rdy_mode == 2) begin
         BUS_RDY = 1'b0;
         lo_left = 0;
      end else if (BUS_WRQ) begin
         BUS_RDY = 1'b0;
         lo_left = lo_len - 1;
      end else if (lo_left > 0) begin
         lo_left--;
      end else begin
         BUS_RDY = 1'b1;
      end
   end

   // Scoreboard monitor for dut
   always @(negedge clkin) begin : mon_main
      wr_t e;
      if (!reset && BUS_WRQ) begin
         n_wrq++;
         wrq_cyc.push_back(cyc);
         $display("dut   write addr=%06h data=%04h word=%0b", ROM_ADDR, ROM_DATA, ROM_WORD_ENABLE);
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_wrq: got write %06h/%04h, expected none", ROM_ADDR, ROM_DATA);
         end else begin
            e = q.pop_front();
            chk("wr_addr", ROM_ADDR, e.a);
            chk("wr_data", ROM_DATA, e.d);
            chk("wr_word", ROM_WORD_ENABLE, e.w);
         end
      end
   end

   // Scoreboard monitor for dut_s
   always @(negedge clkin) begin : mon_split
      wr_t e;
      if (!reset && s_bus_wrq) begin
         $display("dut_s write addr=%06h data=%04h word=%0b", s_rom_addr, s_rom_data, s_rom_word);
         if (qs.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_split_wrq: got write %06h/%04h, expected none", s_rom_addr, s_rom_data);
         end else begin
            e = qs.pop_front();
            chk("split_addr", s_rom_addr, e.a);
            chk("split_data", s_rom_data, e.d);
            chk("split_word", s_rom_word, e.w);
         end
      end
   end

   task automatic wait_drain(input string name, input int bound);
      int k = 0;
      while ((q.size() != 0 || qs.size() != 0) && k < bound) begin
         @(negedge clkin);
         k++;
      end
      n_cmp++;
      if (q.size() != 0 || qs.size() != 0) begin
         n_err++;
         $display("FAIL %s: %0d/%0d writes still pending, expected 0", name, q.size(), qs.size());
      end
   endtask

   task automatic push_main(input logic [23:0] a, input logic [15:0] d, input logic w);
      IN_WRQ  = 1'b1;
      IN_ADDR = a;
      IN_DATA = d;
      IN_WORD = w;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      vec_t vt[20];
      int   n0;
      wr_t  x;

      for (int i = 0; i < 20; i++) begin
         vt[i].a    = 24'hF70000 + 24'(i * 2);
         vt[i].d    = 16'h1000 + 16'(i);
         vt[i].w    = (i % 2) == 1;
         vt[i].lvl  = (i < 16) ? i + 1 : 16;
         vt[i].full = (i >= 15);
         vt[i].ovf  = (i < 16) ? 0 : i - 15;
      end

      reset = 1'b1; IN_WRQ = 1'b0; IN_ADDR = '0; IN_DATA = '0; IN_WORD = 1'b0; OVF_CLR = 1'b0;
      s_wrq = 1'b0; s_addr = '0; s_data = '0; s_word = 1'b0;
      repeat (3) @(negedge clkin);
      reset = 1'b0;
      @(negedge clkin);

      // Reset state
      chk("rst_wrq", BUS_WRQ, 0);
      chk("rst_addr", ROM_ADDR, 0);
      chk("rst_data", ROM_DATA, 0);
      chk("rst_word", ROM_WORD_ENABLE, 0);
      chk("rst_level", FIFO_LEVEL, 0);
      chk("rst_empty", FIFO_EMPTY, 1);
      chk("rst_full", FIFO_FULL, 0);
      chk("rst_ovf", OVF_CNT, 0);
      chk("rst_s_full", s_full, 0);
      chk("rst_s_ovf", s_ovf, 0);

      // 1: single byte write, 3-cycle BUS_RDY low pulse
      rdy_mode = 1; lo_len = 3;
      push_main(24'hF50010, 16'h00AB, 1'b0);
      x = '{24'hF50010, 16'h00AB, 1'b0}; q.push_back(x);
      @(negedge clkin);
      IN_WRQ = 1'b0;
      chk("t1_level", FIFO_LEVEL, 1);
      chk("t1_empty", FIFO_EMPTY, 0);
      @(negedge clkin);
      chk("t1_wrq", BUS_WRQ, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clkin);
         chk("t1_hold_addr", ROM_ADDR, 24'hF50010);
         chk("t1_hold_data", ROM_DATA, 16'h00AB);
         chk("t1_pulse_width", BUS_WRQ, 0);
      end
      repeat (3) @(negedge clkin);
      chk("t1_empty_after", FIFO_EMPTY, 1);
      chk("t1_queue", q.size(), 0);

      // 2: 20 pushes with BUS_RDY low. 16 are queued and 4 are dropped.
      rdy_mode = 2;
      for (int i = 0; i < 20; i++) begin
         push_main(vt[i].a, vt[i].d, vt[i].w);
         if (i < 16) begin
            x = '{vt[i].a, vt[i].d, vt[i].w};
            q.push_back(x);
         end
         @(negedge clkin);
         chk("t2_level", FIFO_LEVEL, vt[i].lvl);
         chk("t2_full", FIFO_FULL, vt[i].full);
         chk("t2_ovf", OVF_CNT, vt[i].ovf);
      end
      IN_WRQ = 1'b0;
      @(negedge clkin);

      // 3: push while full, with a pop on the same edge
      rdy_mode = 1;
      push_main(24'hF7FF00, 16'hBEEF, 1'b1);
      x = '{24'hF7FF00, 16'hBEEF, 1'b1}; q.push_back(x);
      @(negedge clkin);
      IN_WRQ = 1'b0;
      chk("t3_level", FIFO_LEVEL, 16);
      chk("t3_full", FIFO_FULL, 1);
      chk("t3_ovf", OVF_CNT, 4);
      wait_drain("t2_drain", 400);
      repeat (4) @(negedge clkin);
      chk("t2_empty_after", FIFO_EMPTY, 1);

      // 4: word entry at the top of the address space, split and unsplit
      push_main(24'hFFFFFF, 16'h1234, 1'b1);
      x = '{24'hFFFFFF, 16'h1234, 1'b1}; q.push_back(x);
      s_wrq = 1'b1; s_addr = 24'hFFFFFF; s_data = 16'h1234; s_word = 1'b1;
      x = '{24'hFFFFFF, 16'h3434, 1'b0}; qs.push_back(x);
      x = '{24'h000000, 16'h1212, 1'b0}; qs.push_back(x);
      @(negedge clkin);
      IN_WRQ = 1'b0; s_wrq = 1'b0;
      wait_drain("t4_drain", 60);
      repeat (4) @(negedge clkin);

      // 5a: BUS_RDY always high; each write completes on the grace timeout
      rdy_mode = 0;
      repeat (3) @(negedge clkin);
      wrq_cyc.delete();
      for (int i = 0; i < 3; i++) begin
         push_main(24'hF50100 + 24'(i), 16'h5500 + 16'(i), 1'b0);
         x = '{24'hF50100 + 24'(i), 16'h5500 + 16'(i), 1'b0};
         q.push_back(x);
         @(negedge clkin);
      end
      IN_WRQ = 1'b0;
      wait_drain("t5_drain", 60);
      chk("t5_pulses", wrq_cyc.size(), 3);
      if (wrq_cyc.size() == 3) begin
         chk("t5_spacing1", wrq_cyc[1] - wrq_cyc[0], GRACE + 2);
         chk("t5_spacing2", wrq_cyc[2] - wrq_cyc[1], GRACE + 2);
      end
      repeat (4) @(negedge clkin);

      // 5b: reset while in WAIT_HI, with 5 entries still queued
      rdy_mode = 1; lo_len = 30;
      for (int i = 0; i < 6; i++) begin
         push_main(24'hF50200 + 24'(i), 16'h6600 + 16'(i), 1'b0);
         if (i == 0) begin
            x = '{24'hF50200, 16'h6600, 1'b0};
            q.push_back(x);
         end
         @(negedge clkin);
      end
      IN_WRQ = 1'b0;
      chk("t5_level_pre", FIFO_LEVEL, 5);
      chk("t5_busrdy_low", BUS_RDY, 0);
      reset = 1'b1;
      #1;
      chk("t5_rst_wrq", BUS_WRQ, 0);
      chk("t5_rst_addr", ROM_ADDR, 0);
      chk("t5_rst_data", ROM_DATA, 0);
      chk("t5_rst_word", ROM_WORD_ENABLE, 0);
      chk("t5_rst_level", FIFO_LEVEL, 0);
      chk("t5_rst_empty", FIFO_EMPTY, 1);
      chk("t5_rst_ovf", OVF_CNT, 0);
      q.delete();
      repeat (2) @(negedge clkin);
      reset = 1'b0;
      rdy_mode = 0;
      n0 = n_wrq;
      repeat (20) @(negedge clkin);
      chk("t5_no_wrq_after_reset", n_wrq - n0, 0);

      // 6: OVF_CNT saturates at 255, and OVF_CLR wins over a same-cycle drop
      rdy_mode = 2;
      @(negedge clkin);
      push_main(24'hF70000, 16'h0000, 1'b0);
      for (int i = 1; i <= 272; i++) begin
         @(negedge clkin);
         if (i == 270) chk("t6_ovf_254", OVF_CNT, 254);
         if (i == 271) chk("t6_ovf_255", OVF_CNT, 255);
         if (i == 272) chk("t6_ovf_sat", OVF_CNT, 255);
      end
      OVF_CLR = 1'b1;
      @(negedge clkin);
      chk("t6_clr_wins", OVF_CNT, 0);
      OVF_CLR = 1'b0;
      @(negedge clkin);
      chk("t6_count_again", OVF_CNT, 1);
      IN_WRQ = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clkin);
      reset = 1'b0;
      repeat (3) @(negedge clkin);

      chk("end_queue", q.size(), 0);
      chk("end_split_queue", qs.size(), 0);
      chk("end_s_level", s_level, 0);
      chk("end_s_empty", s_empty, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
